temp_monitor_multi: RTL and testbench



---
 rtl/temp_monitor_multi_pkg.sv | 25 ++
 rtl/temp_monitor_multi_channel.sv | 94 +++++++++
 rtl/temp_monitor_multi.sv | 114 +++++++++++
 tb/tb_temp_monitor_multi.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_monitor_multi_pkg.sv
// rtl/temp_monitor_multi_pkg.sv - shared state and display-mode codes for the temperature monitor
package temp_monitor_multi_pkg;

  typedef enum logic [1:0] {
    STATE_NORMAL = 2'd0,
    STATE_HIGH   = 2'd1,
    STATE_LOW    = 2'd2,
    STATE_RAPID  = 2'd3
  } chan_state_e;

  typedef enum logic [1:0] {
    DISP_MODE_TEMP  = 2'd0,
    DISP_MODE_DELTA = 2'd1,
    DISP_MODE_STATE = 2'd2
  } disp_mode_e;

  function automatic disp_mode_e next_mode(input disp_mode_e m);
    case (m)
      DISP_MODE_TEMP:  return DISP_MODE_DELTA;
      DISP_MODE_DELTA: return DISP_MODE_STATE;
      default:         return DISP_MODE_TEMP;
    endcase
  endfunction

endpackage

// File: rtl/temp_monitor_multi_channel.sv
// rtl/temp_monitor_multi_channel.sv - one channel: stored samples, classifier and hysteresis
module temp_channel
  import temp_monitor_multi_pkg::*;
#(
  parameter int W        = 10,
  parameter int HIGH_LIM = 100,
  parameter int LOW_LIM  = -40,
  parameter int RATE_LIM = 10,
  parameter int HOLD     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [W-1:0]  sample_value,
  output logic [W-1:0]  value,
  output logic [W:0]    delta,
  output chan_state_e   state,
  output logic          seen,
  output logic          alarm_entry
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
  localparam logic signed [W:0] HIGH_L = (W+1)'(HIGH_LIM);
  localparam logic signed [W:0] LOW_L  = (W+1)'(LOW_LIM);
  localparam logic signed [W:0] RATE_P = (W+1)'(RATE_LIM);
  localparam logic signed [W:0] RATE_N = (W+1)'(-RATE_LIM);

  logic [W-1:0]      value_q, value_d;
  logic [W-1:0]      prev_q, prev_d;
  logic              seen_q, seen_d;
  logic [HW-1:0]     hold_q, hold_d;
  chan_state_e       state_q, state_d;
  chan_state_e       cand;
  logic signed [W:0] in_ext, val_ext, prev_ext, new_delta;

  assign in_ext   = {sample_value[W-1], sample_value};
  assign val_ext  = {value_q[W-1], value_q};
  assign prev_ext = {prev_q[W-1], prev_q};

  // On the first sample prev is loaded with the sample itself so the reported delta is 0.
  always_comb begin
    new_delta = seen_q ? (in_ext - val_ext) : '0;
    if (in_ext > HIGH_L)                             cand = STATE_HIGH;
    else if (in_ext < LOW_L)                         cand = STATE_LOW;
    else if (new_delta > RATE_P || new_delta < RATE_N) cand = STATE_RAPID;
    else                                             cand = STATE_NORMAL;

    value_d     = value_q;
    prev_d      = prev_q;
    seen_d      = seen_q;
    hold_d      = hold_q;
    state_d     = state_q;
    alarm_entry = 1'b0;
    if (sample_valid) begin
      value_d = sample_value;
      prev_d  = seen_q ? value_q : sample_value;
      seen_d  = 1'b1;
      if (cand != STATE_NORMAL) begin
        state_d     = cand;
        hold_d      = '0;
        alarm_entry = (state_q == STATE_NORMAL);
      end else if (state_q != STATE_NORMAL) begin
        if (hold_q == HW'(HOLD - 1)) begin
          state_d = STATE_NORMAL;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      prev_q  <= '0;
      seen_q  <= 1'b0;
      hold_q  <= '0;
      state_q <= STATE_NORMAL;
    end else begin
      value_q <= value_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  assign value = value_q;
  assign delta = val_ext - prev_ext;
  assign state = state_q;
  assign seen  = seen_q;

endmodule

// File: rtl/temp_monitor_multi.sv
// rtl/temp_monitor_multi.sv - multi-channel temperature monitor: channel decode, display rotator, alarms
module temp_monitor_multi
  import temp_monitor_multi_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int W        = 10,
  parameter int HIGH_LIM = 100,
  parameter int LOW_LIM  = -40,
  parameter int RATE_LIM = 10,
  parameter int HOLD     = 3,
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_chan,
  input  logic [W-1:0]        in_value,
  input  logic                tick,
  input  logic                ack,
  output logic [2*NUM_CH-1:0] chan_state,
  output logic [NUM_CH-1:0]   alarm_mask,
  output logic                alarm_any,
  output logic                alarm_latched,
  output logic                disp_valid,
  output logic [CW-1:0]       disp_chan,
  output logic [1:0]          disp_mode,
  output logic [W:0]          disp_value
);

  logic [W-1:0]      ch_value [NUM_CH];
  logic [W:0]        ch_delta [NUM_CH];
  chan_state_e       ch_state [NUM_CH];
  logic [NUM_CH-1:0] ch_seen, ch_entry, ch_we;

  logic [CW-1:0] disp_chan_q, disp_chan_d;
  disp_mode_e    disp_mode_q, disp_mode_d;
  logic          latched_q, latched_d;
  logic          found;

  // Out-of-range channel indices match no decode term and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = in_valid && (in_chan == CW'(i));

    temp_channel #(
      .W(W), .HIGH_LIM(HIGH_LIM), .LOW_LIM(LOW_LIM), .RATE_LIM(RATE_LIM), .HOLD(HOLD)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (ch_we[i]),
      .sample_value (in_value),
      .value        (ch_value[i]),
      .delta        (ch_delta[i]),
      .state        (ch_state[i]),
      .seen         (ch_seen[i]),
      .alarm_entry  (ch_entry[i])
    );

    assign chan_state[2*i +: 2] = ch_state[i];
    assign alarm_mask[i]        = (ch_state[i] != STATE_NORMAL);
  end

  always_comb begin
    disp_chan_d = disp_chan_q;
    disp_mode_d = disp_mode_q;
    found       = 1'b0;
    if (tick && (|ch_seen)) begin
      disp_mode_d = next_mode(disp_mode_q);
      // Search upward from the next channel; k == NUM_CH lands back on the current one.
      if (disp_mode_q == DISP_MODE_STATE) begin
        for (int k = 1; k <= NUM_CH; k++) begin
          if (!found && ch_seen[(int'(disp_chan_q) + k) % NUM_CH]) begin
            found       = 1'b1;
            disp_chan_d = CW'((int'(disp_chan_q) + k) % NUM_CH);
          end
        end
      end
    end

    if (|ch_entry) latched_d = 1'b1;
    else if (ack)  latched_d = 1'b0;
    else           latched_d = latched_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_chan_q <= '0;
      disp_mode_q <= DISP_MODE_TEMP;
      latched_q   <= 1'b0;
    end else begin
      disp_chan_q <= disp_chan_d;
      disp_mode_q <= disp_mode_d;
      latched_q   <= latched_d;
    end
  end

  always_comb begin
    disp_value = '0;
    if (disp_valid) begin
      case (disp_mode_q)
        DISP_MODE_TEMP:  disp_value = {ch_value[disp_chan_q][W-1], ch_value[disp_chan_q]};
        DISP_MODE_DELTA: disp_value = ch_delta[disp_chan_q];
        DISP_MODE_STATE: disp_value = {{(W-1){1'b0}}, ch_state[disp_chan_q]};
        default:         disp_value = '0;
      endcase
    end
  end

  assign alarm_any     = |alarm_mask;
  assign alarm_latched = latched_q;
  assign disp_valid    = |ch_seen;
  assign disp_chan     = disp_chan_q;
  assign disp_mode     = disp_mode_q;

endmodule

// File: tb/tb_temp_monitor_multi.sv
// tb/tb_temp_monitor_multi.sv - randomized bench with a behavioural model of the temperature monitor
module tb_temp_monitor_multi;
  localparam int NCH  = 4;
  localparam int W    = 10;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, tick, ack;
  logic [1:0]     in_chan;
  logic [W-1:0]   in_value;
  logic [7:0]     chan_state;
  logic [3:0]     alarm_mask;
  logic           alarm_any, alarm_latched, disp_valid;
  logic [1:0]     disp_chan, disp_mode;
  logic [W:0]     disp_value;

  logic           rst6, in_valid6;
  logic [2:0]     in_chan6;
  logic [W-1:0]   in_value6;
  logic [11:0]    chan_state6;
  logic [5:0]     alarm_mask6;
  logic           alarm_any6, alarm_latched6, disp_valid6;
  logic [2:0]     disp_chan6;
  logic [1:0]     disp_mode6;
  logic [W:0]     disp_value6;

  temp_monitor_multi #(.NUM_CH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan), .in_value(in_value),
    .tick(tick), .ack(ack), .chan_state(chan_state), .alarm_mask(alarm_mask),
    .alarm_any(alarm_any), .alarm_latched(alarm_latched), .disp_valid(disp_valid),
    .disp_chan(disp_chan), .disp_mode(disp_mode), .disp_value(disp_value)
  );

  temp_monitor_multi #(.NUM_CH(6), .W(W)) dut6 (
    .clk(clk), .rst(rst6), .in_valid(in_valid6), .in_chan(in_chan6), .in_value(in_value6),
    .tick(1'b0), .ack(1'b0), .chan_state(chan_state6), .alarm_mask(alarm_mask6),
    .alarm_any(alarm_any6), .alarm_latched(alarm_latched6), .disp_valid(disp_valid6),
    .disp_chan(disp_chan6), .disp_mode(disp_mode6), .disp_value(disp_value6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  int m_val [NCH];
  int m_delta [NCH];
  int m_state [NCH];
  int m_hold [NCH];
  bit m_seen [NCH];
  int m_dc, m_mode;
  bit m_latch;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_any_seen();
    bit a = 1'b0;
    for (int i = 0; i < NCH; i++) a |= m_seen[i];
    return a;
  endfunction

  task automatic model_step(input bit r, input bit iv, input int ch, input int v,
                            input bit tk, input bit ak);
    bit entry;
    int d, cand;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_val[i] = 0; m_delta[i] = 0; m_state[i] = 0; m_hold[i] = 0; m_seen[i] = 0;
      end
      m_dc = 0; m_mode = 0; m_latch = 0;
      return;
    end
    if (tk && m_any_seen()) begin
      if (m_mode == 2) begin
        m_mode = 0;
        for (int k = 1; k <= NCH; k++) begin
          if (m_seen[(m_dc + k) % NCH]) begin
            m_dc = (m_dc + k) % NCH;
            break;
          end
        end
      end else begin
        m_mode++;
      end
    end
    entry = 1'b0;
    if (iv && ch < NCH) begin
      d = m_seen[ch] ? v - m_val[ch] : 0;
      if (v > 100)               cand = 1;
      else if (v < -40)          cand = 2;
      else if (d > 10 || d < -10) cand = 3;
      else                       cand = 0;
      if (cand != 0) begin
        if (m_state[ch] == 0) entry = 1'b1;
        m_state[ch] = cand;
        m_hold[ch]  = 0;
      end else if (m_state[ch] != 0) begin
        m_hold[ch]++;
        if (m_hold[ch] == HOLD) begin
          m_state[ch] = 0;
          m_hold[ch]  = 0;
        end
      end
      m_val[ch]   = v;
      m_delta[ch] = d;
      m_seen[ch]  = 1'b1;
    end
    if (entry)   m_latch = 1'b1;
    else if (ak) m_latch = 1'b0;
  endtask

  task automatic step(input bit r, input bit iv, input int ch, input int v,
                      input bit tk, input bit ak);
    rst = r; in_valid = iv; in_chan = ch[1:0]; in_value = v[W-1:0]; tick = tk; ack = ak;
    @(posedge clk);
    model_step(r, iv, ch, v, tk, ak);
    #1;
    rst = 1'b0; in_valid = 1'b0; tick = 1'b0; ack = 1'b0;
  endtask

  task automatic step6(input bit r, input int ch, input int v);
    rst6 = r; in_valid6 = !r; in_chan6 = ch[2:0]; in_value6 = v[W-1:0];
    @(posedge clk);
    #1;
    rst6 = 1'b0; in_valid6 = 1'b0;
  endtask

  always @(negedge clk) begin
    int es, em, ev;
    if (cmp_en) begin
      es = 0; em = 0;
      for (int i = 0; i < NCH; i++) begin
        es |= m_state[i] << (2 * i);
        if (m_state[i] != 0) em |= 1 << i;
      end
      if (!m_any_seen())    ev = 0;
      else if (m_mode == 0) ev = m_val[m_dc];
      else if (m_mode == 1) ev = m_delta[m_dc];
      else                  ev = m_state[m_dc];
      chk("chan_state", chan_state, es);
      chk("alarm_mask", alarm_mask, em);
      chk("alarm_any", alarm_any, int'(em != 0));
      chk("alarm_latched", alarm_latched, int'(m_latch));
      chk("disp_valid", disp_valid, int'(m_any_seen()));
      chk("disp_chan", disp_chan, m_dc);
      chk("disp_mode", disp_mode, m_mode);
      chk("disp_value", int'($signed(disp_value)), ev);
    end
  end

  int rot_ch [7] = '{0, 0, 2, 2, 2, 0, 0};
  int rot_md [7] = '{1, 2, 0, 1, 2, 0, 1};

  initial begin
    int v, ch;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_value = '0; tick = 1'b0; ack = 1'b0;
    rst6 = 1'b1; in_valid6 = 1'b0; in_chan6 = '0; in_value6 = '0;

    step(1, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("rst_mode", disp_mode, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_state", chan_state, 0);

    step(0, 1, 0, 25, 0, 0);
    chk("s0_state", chan_state[1:0], 0);
    chk("s0_any", alarm_any, 0);
    chk("s0_valid", disp_valid, 1);
    chk("s0_chan", disp_chan, 0);
    chk("s0_mode", disp_mode, 0);
    chk("s0_value", int'($signed(disp_value)), 25);

    step(0, 1, 1, 50, 0, 0);
    step(0, 1, 1, 105, 0, 0);
    chk("ch1_mask", alarm_mask, 4'b0010);
    chk("ch1_high", chan_state[3:2], 1);
    chk("ch1_latch", alarm_latched, 1);
    chk("model_delta1", m_delta[1], 55);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("ch1_disp_chan", disp_chan, 1);
    chk("ch1_disp_mode", disp_mode, 1);
    chk("ch1_disp_delta", int'($signed(disp_value)), 55);

    step(0, 0, 0, 0, 0, 1);
    chk("ack_latch", alarm_latched, 0);
    chk("ack_any", alarm_any, 1);

    step(0, 1, 1, 95, 0, 0);
    step(0, 1, 1, 95, 0, 0);
    chk("hold2_state", chan_state[3:2], 1);
    step(0, 1, 1, 95, 0, 0);
    chk("hold3_state", chan_state[3:2], 0);
    chk("hold3_any", alarm_any, 0);

    step(0, 1, 2, 20, 0, 0);
    step(0, 1, 2, 35, 0, 0);
    chk("ch2_rapid", chan_state[5:4], 3);
    step(0, 1, 2, -45, 0, 0);
    chk("ch2_low", chan_state[5:4], 2);
    step(0, 1, 2, 100, 0, 0);
    chk("ch2_lim100", chan_state[5:4], 3);

    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 10, 0, 0);
    step(0, 1, 2, 30, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("rot_chan", disp_chan, rot_ch[i]);
      chk("rot_mode", disp_mode, rot_md[i]);
    end

    step(0, 1, 3, 105, 0, 1);
    chk("ack_set_wins", alarm_latched, 1);
    step(0, 1, 3, 96, 0, 0);
    step(0, 1, 3, 96, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_hold_state", chan_state, 0);
    chk("rst_hold_valid", disp_valid, 0);

    for (int n = 0; n < 3000; n++) begin
      ch = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 1023) - 512;
      else                           v = $urandom_range(0, 190) - 60;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, ch, v,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    step6(1, 0, 0);
    step6(0, 6, 105);
    step6(0, 7, -100);
    chk("oor_state", chan_state6, 0);
    chk("oor_mask", alarm_mask6, 0);
    chk("oor_latch", alarm_latched6, 0);
    chk("oor_valid", disp_valid6, 0);
    step6(0, 5, 105);
    chk("ch5_high", chan_state6[11:10], 1);
    chk("ch5_valid", disp_valid6, 1);
    chk("ch5_latch", alarm_latched6, 1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
